// File: rtl/conv_window_gen_if.sv
// Streaming interface of the 3x3 window generator: pixel-pair input handshake and
// two-channel window output handshake with window coordinates.
interface conv_window_gen_if #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned DW    = 16
);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        pix_1;
  logic [DW-1:0]        pix_2;
  logic                 win_valid;
  logic                 win_ready;
  logic [8:0][DW-1:0]   ifmap_1;
  logic [8:0][DW-1:0]   ifmap_2;
  logic [RW-1:0]        win_row;
  logic [CW-1:0]        win_col;
  logic                 win_last;

  // Pixel producer and window consumer side.
  modport master (
    output in_valid, pix_1, pix_2, win_ready,
    input  in_ready, win_valid, ifmap_1, ifmap_2, win_row, win_col, win_last
  );

  // Window generator side.
  modport slave (
    input  in_valid, pix_1, pix_2, win_ready,
    output in_ready, win_valid, ifmap_1, ifmap_2, win_row, win_col, win_last
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (stride 1, no padding) for two opaque pixel channels,
// using two line buffers per channel and a single-entry registered window output.
module conv_window_gen #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned DW    = 16
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // lb0 holds the previous row, lb1 the row before it.
  logic [DW-1:0] lb0_1 [IMG_W];
  logic [DW-1:0] lb1_1 [IMG_W];
  logic [DW-1:0] lb0_2 [IMG_W];
  logic [DW-1:0] lb1_2 [IMG_W];

  logic [8:0][DW-1:0] win1_q, win1_d;
  logic [8:0][DW-1:0] win2_q, win2_d;
  logic               win_valid_q;
  logic [RW-1:0]      win_row_q;
  logic [CW-1:0]      win_col_q;
  logic               win_last_q;

  logic acc;
  logic col_end;
  logic row_end;
  logic win_ok;

  assign bus.in_ready = !rst && (!win_valid_q || bus.win_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign col_end      = (col_q == CW'(IMG_W - 1));
  assign row_end      = (row_q == RW'(IMG_H - 1));
  // Windows straddling the column wrap or the first two rows are never flagged.
  assign win_ok       = (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Shift each window row left; the new right column is {lb1, lb0, pix} top to bottom.
  always_comb begin
    win1_d = win1_q;
    win2_d = win2_q;
    if (acc) begin
      win1_d = {bus.pix_1, win1_q[8:7], lb0_1[col_q], win1_q[5:4], lb1_1[col_q], win1_q[2:1]};
      win2_d = {bus.pix_2, win2_q[8:7], lb0_2[col_q], win2_q[5:4], lb1_2[col_q], win2_q[2:1]};
    end
  end

  // Line buffers carry no reset; stale contents never reach a flagged window.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_1[col_q] <= lb0_1[col_q];
      lb0_1[col_q] <= bus.pix_1;
      lb1_2[col_q] <= lb0_2[col_q];
      lb0_2[col_q] <= bus.pix_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win1_q      <= '0;
      win2_q      <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win1_q <= win1_d;
      win2_q <= win2_d;
      if (acc) begin
        win_valid_q <= win_ok;
        if (win_ok) begin
          win_row_q  <= row_q - RW'(2);
          win_col_q  <= col_q - CW'(2);
          win_last_q <= row_end && col_end;
        end
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.ifmap_1   = win1_q;
  assign bus.ifmap_2   = win2_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_last  = win_last_q;

endmodule
